enemy_hit_detect: RTL and testbench

Collision and life-cycle stage directly downstream of the enemy position controller. Consumes the enemy's position/visibility (`xpos_out`, `ypos_out`, `on` from the controller), plus the player bullet's position/visibility. Once per frame it decides whether the bullet box overlaps the enemy box. It then drives the enemy through alive → exploding → dead → respawn, and emits hit/bullet-kill pulses and a score for the renderer and bullet controller.

---
 rtl/warblade_pkg.sv | 28 ++
 rtl/box_overlap.sv | 32 +++
 rtl/enemy_hit_detect.sv | 141 ++++++++++++++
 tb/tb_enemy_hit_detect.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warblade_pkg.sv
// Shared definitions for the warblade game pipeline: enemy life-cycle state encoding,
// screen geometry, sprite hitbox sizes and a saturating score adder.
package warblade_pkg;

    typedef enum logic [1:0] {
        StAlive   = 2'd0,
        StExplode = 2'd1,
        StDead    = 2'd2
    } enemy_state_e;

    localparam int unsigned SCREEN_W = 800;
    localparam int unsigned SCREEN_H = 600;

    localparam int unsigned ENEMY_SPRITE_W  = 32;
    localparam int unsigned ENEMY_SPRITE_H  = 32;
    localparam int unsigned BULLET_SPRITE_W = 4;
    localparam int unsigned BULLET_SPRITE_H = 12;

    localparam logic [15:0] SCORE_MAX = 16'hFFFF;

    // Adds two 16-bit values and clamps to SCORE_MAX instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? SCORE_MAX : sum[15:0];
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned rectangle intersection. Box A is (ax, ay, AW x AH), box B is
// (bx, by, BW x BH); right/bottom edges are exclusive and sums are 13 bits so nothing wraps.
module box_overlap #(
    parameter int unsigned AW = 32,
    parameter int unsigned AH = 32,
    parameter int unsigned BW = 4,
    parameter int unsigned BH = 12
) (
    input  logic [11:0] ax,
    input  logic [11:0] ay,
    input  logic [11:0] bx,
    input  logic [11:0] by,
    output logic        overlap
);

    logic [12:0] ax_w, ay_w, bx_w, by_w;
    logic [12:0] a_right, a_bottom, b_right, b_bottom;

    always_comb begin
        ax_w     = {1'b0, ax};
        ay_w     = {1'b0, ay};
        bx_w     = {1'b0, bx};
        by_w     = {1'b0, by};
        a_right  = ax_w + 13'(AW);
        a_bottom = ay_w + 13'(AH);
        b_right  = bx_w + 13'(BW);
        b_bottom = by_w + 13'(BH);
        overlap  = (bx_w < a_right) && (b_right > ax_w) &&
                   (by_w < a_bottom) && (b_bottom > ay_w);
    end

endmodule

// File: rtl/enemy_hit_detect.sv
// Enemy collision and life cycle: registers bullet/enemy overlap, decides one hit per frame
// and walks the enemy through alive -> exploding -> dead -> respawn.
// Score accumulator is present only when ENEMY_HIT_SCORE_EN is defined.
module enemy_hit_detect
    import warblade_pkg::*;
#(
    parameter int unsigned ENEMY_W        = ENEMY_SPRITE_W,
    parameter int unsigned ENEMY_H        = ENEMY_SPRITE_H,
    parameter int unsigned BULLET_W       = BULLET_SPRITE_W,
    parameter int unsigned BULLET_H       = BULLET_SPRITE_H,
    parameter int unsigned EXPLODE_FRAMES = 16,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned POINTS         = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] enemy_xpos,
    input  logic [11:0] enemy_ypos,
    input  logic        enemy_on,
    input  logic [11:0] bullet_xpos,
    input  logic [11:0] bullet_ypos,
    input  logic        bullet_on,
    output logic        hit,
    output logic        bullet_kill,
    output logic        enemy_alive,
    output logic        exploding,
    output logic [15:0] score
);

    localparam logic [7:0] EXPLODE_LOAD = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_FRAMES - 1);

    if (EXPLODE_FRAMES == 0 || EXPLODE_FRAMES > 255 ||
        RESPAWN_FRAMES == 0 || RESPAWN_FRAMES > 255 || POINTS > 65535) begin : g_param_check
        $error("enemy_hit_detect: frame counts must be 1..255 and POINTS must fit 16 bits");
    end

    logic         ovl;
    logic         ovl_q;
    logic         tick_q;
    enemy_state_e state_q, state_d;
    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic         hit_q, hit_d;

    box_overlap #(
        .AW (ENEMY_W),
        .AH (ENEMY_H),
        .BW (BULLET_W),
        .BH (BULLET_H)
    ) u_box_overlap (
        .ax      (enemy_xpos),
        .ay      (enemy_ypos),
        .bx      (bullet_xpos),
        .by      (bullet_ypos),
        .overlap (ovl)
    );

    // Overlap and tick are both delayed one cycle so the decision sees positions from the tick cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            ovl_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            ovl_q  <= ovl & enemy_on & bullet_on;
            tick_q <= frame_tick;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= StAlive;
            frame_cnt_q <= 8'd0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hit_q       <= hit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hit_d       = 1'b0;
        if (tick_q) begin
            case (state_q)
                StAlive: begin
                    if (ovl_q) begin
                        hit_d       = 1'b1;
                        frame_cnt_d = EXPLODE_LOAD;
                        state_d     = StExplode;
                    end
                end
                StExplode: begin
                    if (frame_cnt_q == 8'd0) begin
                        frame_cnt_d = RESPAWN_LOAD;
                        state_d     = StDead;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 8'd1;
                    end
                end
                StDead: begin
                    if (frame_cnt_q == 8'd0) begin
                        state_d = StAlive;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d     = StAlive;
                    frame_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        enemy_alive = (state_q == StAlive);
        exploding   = (state_q == StExplode);
        hit         = hit_q;
        bullet_kill = hit_q;
    end

`ifdef ENEMY_HIT_SCORE_EN
    logic [15:0] score_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            score_q <= 16'd0;
        end else if (hit_d) begin
            score_q <= sat_add16(score_q, 16'(POINTS));
        end
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

endmodule

// File: tb/tb_enemy_hit_detect.sv
// Self-checking bench for enemy_hit_detect: directed life-cycle cases plus randomized frames
// checked against a frame-level reference model; a second fast-cycling instance covers saturation.
module tb_enemy_hit_detect;

    logic        pclk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [11:0] enemy_xpos, enemy_ypos, bullet_xpos, bullet_ypos;
    logic        enemy_on, bullet_on;

    logic        hit, bullet_kill, enemy_alive, exploding;
    logic [15:0] score;
    logic        hit2, kill2, alive2, expl2;
    logic [15:0] score2;

    int checks = 0;
    int passed = 0;

    // Reference model: phase 0 alive, 1 exploding, 2 dead; left = frames remaining in phase.
    int m_phase;
    int m_left;
    int m_score;

    // Observations captured around one frame.
    logic        ob_pre, ob_hit, ob_kill, ob_post, ob_alive, ob_expl;
    logic [15:0] ob_score;

    always #5 pclk = ~pclk;

    enemy_hit_detect u_dut (
        .pclk        (pclk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .enemy_xpos  (enemy_xpos),
        .enemy_ypos  (enemy_ypos),
        .enemy_on    (enemy_on),
        .bullet_xpos (bullet_xpos),
        .bullet_ypos (bullet_ypos),
        .bullet_on   (bullet_on),
        .hit         (hit),
        .bullet_kill (bullet_kill),
        .enemy_alive (enemy_alive),
        .exploding   (exploding),
        .score       (score)
    );

    enemy_hit_detect #(
        .EXPLODE_FRAMES (1),
        .RESPAWN_FRAMES (1)
    ) u_dut_fast (
        .pclk        (pclk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .enemy_xpos  (enemy_xpos),
        .enemy_ypos  (enemy_ypos),
        .enemy_on    (enemy_on),
        .bullet_xpos (bullet_xpos),
        .bullet_ypos (bullet_ypos),
        .bullet_on   (bullet_on),
        .hit         (hit2),
        .bullet_kill (kill2),
        .enemy_alive (alive2),
        .exploding   (expl2),
        .score       (score2)
    );

    function automatic bit ref_overlap(int ex, int ey, int eon, int bx, int by, int bon);
        return (eon != 0) && (bon != 0) && (bx < ex + 32) && (bx + 4 > ex) &&
               (by < ey + 32) && (by + 12 > ey);
    endfunction

    function automatic bit model_frame(bit ovl);
        bit h = 1'b0;
        if (m_phase == 0) begin
            if (ovl) begin
                h       = 1'b1;
                m_phase = 1;
                m_left  = 16;
`ifdef ENEMY_HIT_SCORE_EN
                m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
`endif
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_phase == 1) begin
                    m_phase = 2;
                    m_left  = 60;
                end else begin
                    m_phase = 0;
                end
            end
        end
        return h;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_left  = 0;
        m_score = 0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        frame_tick = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one frame tick with the given positions, then scrambles positions so only the
    // tick-cycle positions can influence the decision. Starts and ends on a falling edge.
    task automatic do_frame(int ex, int ey, int eon, int bx, int by, int bon);
        enemy_xpos  = 12'(ex);
        enemy_ypos  = 12'(ey);
        enemy_on    = eon[0];
        bullet_xpos = 12'(bx);
        bullet_ypos = 12'(by);
        bullet_on   = bon[0];
        frame_tick  = 1'b1;
        @(negedge pclk);
        frame_tick  = 1'b0;
        enemy_xpos  = 12'($urandom_range(0, 799));
        enemy_ypos  = 12'($urandom_range(0, 599));
        bullet_xpos = 12'($urandom_range(0, 799));
        bullet_ypos = 12'($urandom_range(0, 599));
        enemy_on    = 1'($urandom_range(0, 1));
        bullet_on   = 1'($urandom_range(0, 1));
        ob_pre = hit;
        @(negedge pclk);
        ob_hit   = hit;
        ob_kill  = bullet_kill;
        ob_alive = enemy_alive;
        ob_expl  = exploding;
        ob_score = score;
        @(negedge pclk);
        ob_post = hit;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        frame_tick = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        checks++; if (hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", hit); else passed++;
        checks++; if (bullet_kill !== 1'b0) $display("FAIL reset_kill: got %0b want 0", bullet_kill); else passed++;
        checks++; if (enemy_alive !== 1'b1) $display("FAIL reset_alive: got %0b want 1", enemy_alive); else passed++;
        checks++; if (exploding !== 1'b0) $display("FAIL reset_expl: got %0b want 0", exploding); else passed++;
        checks++; if (score !== 16'd0) $display("FAIL reset_score: got %0d want 0", score); else passed++;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_full_overlap();
        bit e;
        do_reset();
        do_frame(100, 100, 1, 110, 110, 1);
        e = model_frame(ref_overlap(100, 100, 1, 110, 110, 1));
        checks++; if (ob_pre !== 1'b0) $display("FAIL full_pre: hit early got %0b want 0", ob_pre); else passed++;
        checks++; if (ob_hit !== e) $display("FAIL full_hit: got %0b want %0b", ob_hit, e); else passed++;
        checks++; if (ob_kill !== e) $display("FAIL full_kill: got %0b want %0b", ob_kill, e); else passed++;
        checks++; if (ob_post !== 1'b0) $display("FAIL full_post: got %0b want 0", ob_post); else passed++;
        checks++; if (ob_score !== 16'(m_score)) $display("FAIL full_score: got %0d want %0d", ob_score, m_score); else passed++;
        checks++; if (ob_expl !== (m_phase == 1)) $display("FAIL full_expl: got %0b want %0b", ob_expl, m_phase == 1); else passed++;
        checks++; if (ob_alive !== (m_phase == 0)) $display("FAIL full_alive: got %0b want %0b", ob_alive, m_phase == 0); else passed++;
    endtask

    task automatic test_edge();
        bit e;
        do_reset();
        do_frame(100, 100, 1, 132, 110, 1);
        e = model_frame(ref_overlap(100, 100, 1, 132, 110, 1));
        checks++; if (ob_hit !== e) $display("FAIL edge_132: got %0b want %0b", ob_hit, e); else passed++;
        do_reset();
        do_frame(100, 100, 1, 131, 110, 1);
        e = model_frame(ref_overlap(100, 100, 1, 131, 110, 1));
        checks++; if (ob_hit !== e) $display("FAIL edge_131: got %0b want %0b", ob_hit, e); else passed++;
        do_reset();
        do_frame(100, 100, 1, 110, 88, 1);
        e = model_frame(ref_overlap(100, 100, 1, 110, 88, 1));
        checks++; if (ob_hit !== e) $display("FAIL edge_y88: got %0b want %0b", ob_hit, e); else passed++;
        do_reset();
        do_frame(100, 100, 1, 96, 110, 1);
        e = model_frame(ref_overlap(100, 100, 1, 96, 110, 1));
        checks++; if (ob_hit !== e) $display("FAIL edge_x96: got %0b want %0b", ob_hit, e); else passed++;
    endtask

    task automatic test_lifecycle();
        bit e;
        int bad = 0;
        do_reset();
        do_frame(200, 300, 1, 210, 310, 1);
        e = model_frame(1'b1);
        for (int f = 0; f < 76; f++) begin
            do_frame(200, 300, 1, 210, 310, 1);
            e = model_frame(ref_overlap(200, 300, 1, 210, 310, 1));
            if (ob_hit !== e || ob_alive !== (m_phase == 0) || ob_expl !== (m_phase == 1)) begin
                if (bad == 0)
                    $display("FAIL life_frame%0d: hit %0b alive %0b expl %0b want %0b %0b %0b",
                             f, ob_hit, ob_alive, ob_expl, e, m_phase == 0, m_phase == 1);
                bad++;
            end
            if (f == 15) begin
                checks++; if (ob_alive !== 1'b0 || ob_expl !== 1'b0)
                    $display("FAIL life_dead: alive %0b expl %0b want 0 0", ob_alive, ob_expl); else passed++;
            end
        end
        checks++; if (bad != 0) $display("FAIL life_frames: %0d bad frames want 0", bad); else passed++;
        checks++; if (ob_alive !== 1'b1) $display("FAIL life_respawn: got %0b want 1", ob_alive); else passed++;
    endtask

    task automatic test_gating();
        bit e;
        do_reset();
        do_frame(100, 100, 1, 110, 110, 0);
        e = model_frame(ref_overlap(100, 100, 1, 110, 110, 0));
        checks++; if (ob_hit !== e) $display("FAIL gate_bullet: got %0b want %0b", ob_hit, e); else passed++;
        do_frame(100, 100, 0, 110, 110, 1);
        e = model_frame(ref_overlap(100, 100, 0, 110, 110, 1));
        checks++; if (ob_hit !== e) $display("FAIL gate_enemy: got %0b want %0b", ob_hit, e); else passed++;
        checks++; if (ob_score !== 16'(m_score)) $display("FAIL gate_score: got %0d want %0d", ob_score, m_score); else passed++;
        checks++; if (ob_alive !== 1'b1) $display("FAIL gate_alive: got %0b want 1", ob_alive); else passed++;
    endtask

    task automatic test_random();
        bit e;
        int bad = 0;
        int hits = 0;
        do_reset();
        for (int f = 0; f < 700; f++) begin
            int ex  = int'($urandom_range(0, 760));
            int ey  = int'($urandom_range(0, 560));
            int bx  = ex + int'($urandom_range(0, 50)) - 10;
            int by  = ey + int'($urandom_range(0, 60)) - 20;
            int eon = ($urandom_range(0, 7) != 0) ? 1 : 0;
            int bon = ($urandom_range(0, 7) != 0) ? 1 : 0;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            do_frame(ex, ey, eon, bx, by, bon);
            e = model_frame(ref_overlap(ex, ey, eon, bx, by, bon));
            if (e) hits++;
            if (ob_hit !== e || ob_kill !== e || ob_pre !== 1'b0 || ob_post !== 1'b0 ||
                ob_alive !== (m_phase == 0) || ob_expl !== (m_phase == 1) ||
                ob_score !== 16'(m_score)) begin
                if (bad < 4)
                    $display("FAIL rand_frame%0d: hit %0b kill %0b alive %0b expl %0b score %0d want %0b %0b %0b %0b %0d",
                             f, ob_hit, ob_kill, ob_alive, ob_expl, ob_score,
                             e, e, m_phase == 0, m_phase == 1, m_score);
                bad++;
            end
        end
        checks++; if (bad != 0) $display("FAIL rand_frames: %0d bad frames want 0", bad); else passed++;
        checks++; if (hits == 0) $display("FAIL rand_coverage: got %0d hits want >0", hits); else passed++;
    endtask

    task automatic test_reset_mid_explode();
        bit e;
        do_reset();
        do_frame(100, 100, 1, 110, 110, 1);
        e = model_frame(1'b1);
        for (int f = 0; f < 5; f++) begin
            do_frame(100, 100, 1, 110, 110, 1);
            e = model_frame(1'b1);
        end
        checks++; if (ob_expl !== 1'b1) $display("FAIL mid_pre_expl: got %0b want 1", ob_expl); else passed++;
        enemy_xpos = 12'd100; enemy_ypos = 12'd100; enemy_on = 1'b1;
        bullet_xpos = 12'd110; bullet_ypos = 12'd110; bullet_on = 1'b1;
        rst        = 1'b1;
        frame_tick = 1'b1;
        @(negedge pclk);
        rst        = 1'b0;
        frame_tick = 1'b0;
        model_reset();
        checks++; if (enemy_alive !== 1'b1) $display("FAIL mid_alive: got %0b want 1", enemy_alive); else passed++;
        checks++; if (exploding !== 1'b0) $display("FAIL mid_expl: got %0b want 0", exploding); else passed++;
        checks++; if (score !== 16'd0) $display("FAIL mid_score: got %0d want 0", score); else passed++;
        checks++; if (hit !== 1'b0) $display("FAIL mid_hit: got %0b want 0", hit); else passed++;
        @(negedge pclk);
        checks++; if (hit !== 1'b0) $display("FAIL mid_hit_after: got %0b want 0", hit); else passed++;
    endtask

    // Fast instance: one hit every three consecutive ticks; 6560 hits run past saturation.
    task automatic test_back_to_back();
        int          hits2 = 0;
        int          kill_bad = 0;
        int          wraps = 0;
        logic [15:0] prev = 16'd0;
        logic [15:0] at_6553 = 16'd0;
        int          exp_sat;
        int          exp_6553;
`ifdef ENEMY_HIT_SCORE_EN
        exp_sat  = 65535;
        exp_6553 = 65530;
`else
        exp_sat  = 0;
        exp_6553 = 0;
`endif
        enemy_xpos = 12'd400; enemy_ypos = 12'd300; enemy_on = 1'b1;
        bullet_xpos = 12'd410; bullet_ypos = 12'd310; bullet_on = 1'b1;
        do_reset();
        frame_tick = 1'b1;
        for (int c = 0; c < 3 * 6560 + 3; c++) begin
            if (c == 3 * 6560) frame_tick = 1'b0;
            @(negedge pclk);
            if (kill2 !== hit2) kill_bad++;
            if (hit2 === 1'b1) begin
                hits2++;
                if (hits2 == 6553) at_6553 = score2;
            end
            if (score2 < prev) wraps++;
            prev = score2;
        end
        checks++; if (hits2 != 6560) $display("FAIL b2b_hits: got %0d want 6560", hits2); else passed++;
        checks++; if (kill_bad != 0) $display("FAIL b2b_kill: %0d cycles kill!=hit want 0", kill_bad); else passed++;
        checks++; if (at_6553 !== 16'(exp_6553)) $display("FAIL b2b_score6553: got %0d want %0d", at_6553, exp_6553); else passed++;
        checks++; if (score2 !== 16'(exp_sat)) $display("FAIL b2b_sat: got %0d want %0d", score2, exp_sat); else passed++;
        checks++; if (wraps != 0) $display("FAIL b2b_wrap: %0d decreases want 0", wraps); else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        enemy_xpos  = 12'd0;
        enemy_ypos  = 12'd0;
        enemy_on    = 1'b0;
        bullet_xpos = 12'd0;
        bullet_ypos = 12'd0;
        bullet_on   = 1'b0;
        model_reset();
        @(negedge pclk);
        test_reset();
        test_full_overlap();
        test_edge();
        test_lifecycle();
        test_gating();
        test_random();
        test_reset_mid_explode();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
